seg7_hex_capture: RTL and testbench

SEG7_HEX_CAPTURE -- requirements
Module: seg7_hex_capture

---
 rtl/seg7_hex_capture.sv | 156 +++++++++++++++
 tb/tb_seg7_hex_capture.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_hex_capture.sv
// Captures a two-digit seven-segment display, decoding a byte once the pattern has settled.
// Optional SEG_ERR_COUNT_EN adds a saturating ErrCount output counting illegal-glyph decodes.
module seg7_hex_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic [0:6] HEX1,
  input  logic [0:6] HEX0,
  output logic [7:0] Value,
  output logic       Valid,
  output logic       Error,
  output logic       Stable
`ifdef SEG_ERR_COUNT_EN
  ,
  output logic [7:0] ErrCount
`endif
);

  localparam logic [7:0] SETTLE_TARGET = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] sample_q, sample_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        stable_q, stable_d;

  logic [13:0] pattern;
  logic        samePattern;
  logic [4:0]  hiGlyph, loGlyph;

  // Returns {legal, digit}; segment string is a..g left to right, 0 = lit.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = 5'h10;
      7'b1001111: res = 5'h11;
      7'b0010010: res = 5'h12;
      7'b0000110: res = 5'h13;
      7'b1001100: res = 5'h14;
      7'b0100100: res = 5'h15;
      7'b0100000: res = 5'h16;
      7'b0001111: res = 5'h17;
      7'b0000000: res = 5'h18;
      7'b0000100: res = 5'h19;
      7'b0001000: res = 5'h1A;
      7'b1100000: res = 5'h1B;
      7'b0110001: res = 5'h1C;
      7'b1000010: res = 5'h1D;
      7'b0110000: res = 5'h1E;
      7'b0111000: res = 5'h1F;
      default:    res = 5'h00;
    endcase
    return res;
  endfunction

  assign pattern     = {HEX1, HEX0};
  assign samePattern = (pattern == sample_q);
  assign hiGlyph     = decodeGlyph(sample_q[13:7]);
  assign loGlyph     = decodeGlyph(sample_q[6:0]);

  // The decision is taken only on an edge that still matches S, so a change on that edge wins.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    count_d  = count_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (!Enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          sample_d = pattern;
          count_d  = 8'd0;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (!samePattern) begin
            sample_d = pattern;
            count_d  = 8'd1;
          end else if (count_q >= SETTLE_TARGET) begin
            state_d = HOLD;
            if (hiGlyph[4] && loGlyph[4]) begin
              value_d = {hiGlyph[3:0], loGlyph[3:0]};
              valid_d = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end else if (count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
          end
        end
        HOLD: begin
          if (!samePattern) begin
            sample_d = pattern;
            count_d  = 8'd1;
            state_d  = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    stable_d = (state_d == HOLD);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      sample_q <= '1;
      count_q  <= 8'd0;
      value_q  <= 8'h00;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      count_q  <= count_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      stable_q <= stable_d;
    end
  end

  assign Value  = value_q;
  assign Valid  = valid_q;
  assign Error  = error_q;
  assign Stable = stable_q;

`ifdef SEG_ERR_COUNT_EN
  logic [7:0] errCount_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      errCount_q <= 8'h00;
    end else if (error_d && (errCount_q != 8'hFF)) begin
      errCount_q <= errCount_q + 8'd1;
    end
  end

  assign ErrCount = errCount_q;
`endif

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Directed self-checking bench for seg7_hex_capture at the default SETTLE_CYCLES of 4.
module tb_seg7_hex_capture;

  logic       Clock;
  logic       Resetn;
  logic       Enable;
  logic [0:6] HEX1;
  logic [0:6] HEX0;
  logic [7:0] Value;
  logic       Valid;
  logic       Error;
  logic       Stable;
`ifdef SEG_ERR_COUNT_EN
  logic [7:0] ErrCount;
`endif

  int tests;
  int fails;

  seg7_hex_capture #(.SETTLE_CYCLES(4)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Enable  (Enable),
    .HEX1    (HEX1),
    .HEX0    (HEX0),
    .Value   (Value),
    .Valid   (Valid),
    .Error   (Error),
    .Stable  (Stable)
`ifdef SEG_ERR_COUNT_EN
    ,
    .ErrCount(ErrCount)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Hand-typed glyph table, segments a..g left to right, 0 = lit.
  function automatic logic [6:0] glyphOf(input int d);
    logic [6:0] g;
    case (d)
      0: g = 7'b0000001;  1: g = 7'b1001111;  2: g = 7'b0010010;  3: g = 7'b0000110;
      4: g = 7'b1001100;  5: g = 7'b0100100;  6: g = 7'b0100000;  7: g = 7'b0001111;
      8: g = 7'b0000000;  9: g = 7'b0000100; 10: g = 7'b0001000; 11: g = 7'b1100000;
      12: g = 7'b0110001; 13: g = 7'b1000010; 14: g = 7'b0110000; default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  task automatic applyStimulus(input logic [6:0] hi, input logic [6:0] lo, input logic en);
    HEX1   = hi;
    HEX0   = lo;
    Enable = en;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    tests++; if (Value !== 8'h00) begin fails++; $display("[TB] FAIL reset_value: got %h expected 00", Value); end
    tests++; if (Valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", Valid); end
    tests++; if (Error !== 1'b0) begin fails++; $display("[TB] FAIL reset_error: got %b expected 0", Error); end
    tests++; if (Stable !== 1'b0) begin fails++; $display("[TB] FAIL reset_stable: got %b expected 0", Stable); end
`ifdef SEG_ERR_COUNT_EN
    tests++; if (ErrCount !== 8'h00) begin fails++; $display("[TB] FAIL reset_errcount: got %h expected 00", ErrCount); end
`endif
  endtask

  // 0x3A held from the first enabled edge: pulse visible after the sixth edge.
  task automatic test_basic();
    applyStimulus(7'b0000110, 7'b0001000, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      tests++;
      if (Valid !== (e == 6)) begin fails++; $display("[TB] FAIL basic_valid edge %0d: got %b expected %b", e, Valid, (e == 6)); end
      if (e == 6) begin
        tests++; if (Value !== 8'h3A) begin fails++; $display("[TB] FAIL basic_value: got %h expected 3A", Value); end
        tests++; if (Stable !== 1'b1) begin fails++; $display("[TB] FAIL basic_stable: got %b expected 1", Stable); end
      end
    end
  endtask

  task automatic test_glitch();
    applyStimulus(7'b0000110, 7'b0100100, 1'b1);
    tick();
    tests++; if (Valid !== 1'b0) begin fails++; $display("[TB] FAIL glitch_valid: got %b expected 0", Valid); end
    tests++; if (Stable !== 1'b0) begin fails++; $display("[TB] FAIL glitch_stable: got %b expected 0", Stable); end
    applyStimulus(7'b0000110, 7'b0001000, 1'b1);
    tick();
    tests++; if (Valid !== 1'b0) begin fails++; $display("[TB] FAIL glitch_return_valid: got %b expected 0", Valid); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if (Valid !== (k == 4)) begin fails++; $display("[TB] FAIL glitch_resettle edge %0d: got %b expected %b", k, Valid, (k == 4)); end
    end
    tests++; if (Value !== 8'h3A) begin fails++; $display("[TB] FAIL glitch_value: got %h expected 3A", Value); end
  endtask

  task automatic test_illegal();
    applyStimulus(7'b1111111, 7'b0000001, 1'b1);
    for (int k = 0; k <= 5; k++) begin
      tick();
      tests++;
      if (Error !== (k == 4)) begin fails++; $display("[TB] FAIL illegal_error edge %0d: got %b expected %b", k, Error, (k == 4)); end
      tests++;
      if (Valid !== 1'b0) begin fails++; $display("[TB] FAIL illegal_valid edge %0d: got %b expected 0", k, Valid); end
    end
    tests++; if (Value !== 8'h3A) begin fails++; $display("[TB] FAIL illegal_value: got %h expected 3A", Value); end
`ifdef SEG_ERR_COUNT_EN
    tests++; if (ErrCount !== 8'h01) begin fails++; $display("[TB] FAIL illegal_errcount: got %h expected 01", ErrCount); end
`endif
  endtask

  task automatic test_enable_drop();
    applyStimulus(glyphOf(1), glyphOf(2), 1'b1);
    tick();
    tick();
    applyStimulus(glyphOf(1), glyphOf(2), 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ((Valid !== 1'b0) || (Error !== 1'b0) || (Stable !== 1'b0)) begin
        fails++; $display("[TB] FAIL disabled_outputs: got v=%b e=%b s=%b expected 0 0 0", Valid, Error, Stable);
      end
    end
    tests++; if (Value !== 8'h3A) begin fails++; $display("[TB] FAIL disabled_value: got %h expected 3A", Value); end
    applyStimulus(glyphOf(1), glyphOf(2), 1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick();
      tests++;
      if (Valid !== (e == 6)) begin fails++; $display("[TB] FAIL reenable_valid edge %0d: got %b expected %b", e, Valid, (e == 6)); end
    end
    tests++; if (Value !== 8'h12) begin fails++; $display("[TB] FAIL reenable_value: got %h expected 12", Value); end
  endtask

  task automatic test_async_reset();
    applyStimulus(glyphOf(15), glyphOf(15), 1'b1);
    for (int k = 0; k <= 5; k++) begin
      tick();
      tests++;
      if (Valid !== (k == 4)) begin fails++; $display("[TB] FAIL ff_valid edge %0d: got %b expected %b", k, Valid, (k == 4)); end
    end
    tests++; if (Value !== 8'hFF) begin fails++; $display("[TB] FAIL ff_value: got %h expected FF", Value); end
    tests++; if (Stable !== 1'b1) begin fails++; $display("[TB] FAIL ff_stable: got %b expected 1", Stable); end
    #2 Resetn = 1'b0;
    #1;
    tests++; if (Value !== 8'h00) begin fails++; $display("[TB] FAIL async_value: got %h expected 00", Value); end
    tests++; if (Stable !== 1'b0) begin fails++; $display("[TB] FAIL async_stable: got %b expected 0", Stable); end
    Resetn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      tests++;
      if (Valid !== (e == 6)) begin fails++; $display("[TB] FAIL recapture_valid edge %0d: got %b expected %b", e, Valid, (e == 6)); end
    end
    tests++; if (Value !== 8'hFF) begin fails++; $display("[TB] FAIL recapture_value: got %h expected FF", Value); end
  endtask

  task automatic test_sweep();
    int pulses;
    int errs;
    for (int p = 0; p < 256; p++) begin
      applyStimulus(glyphOf(p / 16), glyphOf(p % 16), 1'b1);
      pulses = 0;
      errs   = 0;
      for (int k = 0; k <= 4; k++) begin
        tick();
        if (Valid === 1'b1) pulses++;
        if (Error === 1'b1) errs++;
      end
      tests++;
      if ((pulses != 1) || (errs != 0)) begin
        fails++; $display("[TB] FAIL sweep_pulses pair %02h: got valid=%0d error=%0d expected 1 0", p, pulses, errs);
      end
      tests++;
      if (Value !== 8'(p)) begin fails++; $display("[TB] FAIL sweep_value: got %h expected %02h", Value, p); end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    Resetn = 1'b0;
    applyStimulus(7'b1111111, 7'b1111111, 1'b0);
    #12;
    test_reset();
    Resetn = 1'b1;
    test_basic();
    test_glitch();
    test_illegal();
    test_enable_drop();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
